// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped branch target buffer with 2-bit saturating
// counters, combinational lookup, resolve-time misprediction detection and
// branch / misprediction statistics counters.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   PC_curr, PC_next          fetch PC being looked up and its fall-through
//   predict_taken             lookup hit and counter predicts taken
//   predicted_PC              next fetch address chosen by the predictor
//   update, stall             a branch resolves this cycle / block state writes
//   br_PC, br_PC_next         resolving branch PC and its fall-through
//   actual_taken/_target      resolved outcome from branch control
//   pred_taken_ID/_target_ID  prediction that travelled with the branch
//   mispredicted, recovery_PC redirect request and correct next PC
//   br_count, mis_count       saturating statistics counters
module branch_predictor #(
  parameter int unsigned IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC_curr,
  input  logic [15:0] PC_next,
  output logic        predict_taken,
  output logic [15:0] predicted_PC,
  input  logic        update,
  input  logic        stall,
  input  logic [15:0] br_PC,
  input  logic [15:0] br_PC_next,
  input  logic        actual_taken,
  input  logic [15:0] actual_target,
  input  logic        pred_taken_ID,
  input  logic [15:0] pred_target_ID,
  output logic        mispredicted,
  output logic [15:0] recovery_PC,
  output logic [15:0] br_count,
  output logic [15:0] mis_count
);

  localparam int unsigned Entries = 2 ** IDX_W;
  localparam int unsigned TagW    = 16 - IDX_W - 1;

  logic              valid_q [Entries];
  logic [TagW-1:0]   tag_q   [Entries];
  logic [15:0]       tgt_q   [Entries];
  logic [1:0]        ctr_q   [Entries];
  logic [15:0]       br_cnt_q;
  logic [15:0]       mis_cnt_q;

  logic [IDX_W-1:0]  rd_idx;
  logic [TagW-1:0]   rd_tag;
  logic              rd_hit;
  logic [IDX_W-1:0]  wr_idx;
  logic [TagW-1:0]   wr_tag;
  logic              wr_hit;
  logic              wr_en;

  // Bit 0 of both PCs is always zero for aligned instructions.
  logic unused_pc_lsb;
  assign unused_pc_lsb = PC_curr[0] ^ br_PC[0];

  // Lookup reads the registered table, so a same-cycle write is not visible.
  assign rd_idx        = PC_curr[IDX_W:1];
  assign rd_tag        = PC_curr[15:IDX_W+1];
  assign rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign predict_taken = rd_hit && ctr_q[rd_idx][1];
  assign predicted_PC  = predict_taken ? tgt_q[rd_idx] : PC_next;

  assign wr_idx = br_PC[IDX_W:1];
  assign wr_tag = br_PC[15:IDX_W+1];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign wr_en  = update && !stall;

  // A taken branch predicted taken still mispredicts if the target moved (BR).
  assign mispredicted = update && ((pred_taken_ID != actual_taken) ||
                        (actual_taken && pred_taken_ID && (pred_target_ID != actual_target)));
  assign recovery_PC  = actual_taken ? actual_target : br_PC_next;

  assign br_count  = br_cnt_q;
  assign mis_count = mis_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= 16'h0000;
        ctr_q[i]   <= 2'b01;
      end
      br_cnt_q  <= 16'h0000;
      mis_cnt_q <= 16'h0000;
    end else if (wr_en) begin
      if (wr_hit) begin
        if (actual_taken) begin
          tgt_q[wr_idx] <= actual_target;
          if (ctr_q[wr_idx] != 2'b11) ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'b01;
        end else if (ctr_q[wr_idx] != 2'b00) begin
          ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'b01;
        end
      end else if (actual_taken) begin
        // Allocate over any previous occupant, starting weakly taken.
        valid_q[wr_idx] <= 1'b1;
        tag_q[wr_idx]   <= wr_tag;
        tgt_q[wr_idx]   <= actual_target;
        ctr_q[wr_idx]   <= 2'b10;
      end
      if (br_cnt_q != 16'hFFFF) br_cnt_q <= br_cnt_q + 16'h0001;
      if (mispredicted && (mis_cnt_q != 16'hFFFF)) mis_cnt_q <= mis_cnt_q + 16'h0001;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] PC_curr, PC_next;
  logic        predict_taken;
  logic [15:0] predicted_PC;
  logic        update, stall;
  logic [15:0] br_PC, br_PC_next;
  logic        actual_taken;
  logic [15:0] actual_target;
  logic        pred_taken_ID;
  logic [15:0] pred_target_ID;
  logic        mispredicted;
  logic [15:0] recovery_PC, br_count, mis_count;

  int n_tests = 0;
  int n_fail  = 0;

  branch_predictor #(.IDX_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .PC_curr       (PC_curr),
    .PC_next       (PC_next),
    .predict_taken (predict_taken),
    .predicted_PC  (predicted_PC),
    .update        (update),
    .stall         (stall),
    .br_PC         (br_PC),
    .br_PC_next    (br_PC_next),
    .actual_taken  (actual_taken),
    .actual_target (actual_target),
    .pred_taken_ID (pred_taken_ID),
    .pred_target_ID(pred_target_ID),
    .mispredicted  (mispredicted),
    .recovery_PC   (recovery_PC),
    .br_count      (br_count),
    .mis_count     (mis_count)
  );

  always #5 clk = ~clk;

  // Advance one edge; sample 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [15:0] pc);
    PC_curr = pc;
    PC_next = pc + 16'd2;
    #1;
  endtask

  task automatic set_br(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                        input logic ptk, input logic [15:0] ptg);
    update         = 1'b1;
    br_PC          = pc;
    br_PC_next     = pc + 16'd2;
    actual_taken   = tk;
    actual_target  = tgt;
    pred_taken_ID  = ptk;
    pred_target_ID = ptg;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    lookup(16'h0010);
    n_tests++;
    if (predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_pt got %0b exp 0", predict_taken);
    end
    n_tests++;
    if (predicted_PC !== 16'h0012) begin
      n_fail++; $display("FAIL reset_ppc got %h exp 0012", predicted_PC);
    end
    n_tests++;
    if (br_count !== 16'h0 || mis_count !== 16'h0) begin
      n_fail++; $display("FAIL reset_cnt got %h/%h exp 0000/0000", br_count, mis_count);
    end
    n_tests++;
    if (mispredicted !== 1'b0) begin
      n_fail++; $display("FAIL reset_mis got %0b exp 0", mispredicted);
    end
  endtask

  task automatic test_allocate();
    lookup(16'h0010);
    set_br(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0012);
    n_tests++;
    if (mispredicted !== 1'b1 || recovery_PC !== 16'h0040) begin
      n_fail++; $display("FAIL alloc_mis got %0b/%h exp 1/0040", mispredicted, recovery_PC);
    end
    n_tests++;
    if (predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL rdw_prewrite got %0b exp 0", predict_taken);
    end
    step();
    update = 1'b0;
    #1;
    n_tests++;
    if (predict_taken !== 1'b1 || predicted_PC !== 16'h0040) begin
      n_fail++; $display("FAIL alloc_hit got %0b/%h exp 1/0040", predict_taken, predicted_PC);
    end
    n_tests++;
    if (br_count !== 16'd1 || mis_count !== 16'd1) begin
      n_fail++; $display("FAIL alloc_cnt got %0d/%0d exp 1/1", br_count, mis_count);
    end
  endtask

  task automatic test_saturation();
    lookup(16'h0010);
    for (int i = 0; i < 4; i++) begin
      set_br(16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
      step();
    end
    set_br(16'h0010, 1'b0, 16'h0040, 1'b1, 16'h0040);
    n_tests++;
    if (mispredicted !== 1'b1 || recovery_PC !== 16'h0012) begin
      n_fail++; $display("FAIL nt_mis got %0b/%h exp 1/0012", mispredicted, recovery_PC);
    end
    step();
    n_tests++;
    if (predict_taken !== 1'b1) begin
      n_fail++; $display("FAIL sat_first_nt got %0b exp 1", predict_taken);
    end
    step();
    update = 1'b0;
    #1;
    n_tests++;
    if (predict_taken !== 1'b0 || predicted_PC !== 16'h0012) begin
      n_fail++; $display("FAIL sat_second_nt got %0b/%h exp 0/0012", predict_taken, predicted_PC);
    end
    n_tests++;
    if (br_count !== 16'd7 || mis_count !== 16'd3) begin
      n_fail++; $display("FAIL sat_cnt got %0d/%0d exp 7/3", br_count, mis_count);
    end
  endtask

  task automatic test_not_taken_miss();
    lookup(16'h0104);
    set_br(16'h0104, 1'b0, 16'h0400, 1'b0, 16'h0106);
    n_tests++;
    if (mispredicted !== 1'b0 || recovery_PC !== 16'h0106) begin
      n_fail++; $display("FAIL ntmiss_mis got %0b/%h exp 0/0106", mispredicted, recovery_PC);
    end
    step();
    update = 1'b0;
    #1;
    n_tests++;
    if (predict_taken !== 1'b0 || predicted_PC !== 16'h0106) begin
      n_fail++; $display("FAIL ntmiss_noalloc got %0b/%h exp 0/0106", predict_taken, predicted_PC);
    end
    n_tests++;
    if (br_count !== 16'd8 || mis_count !== 16'd3) begin
      n_fail++; $display("FAIL ntmiss_cnt got %0d/%0d exp 8/3", br_count, mis_count);
    end
  endtask

  task automatic test_alias();
    set_br(16'h0020, 1'b1, 16'h0200, 1'b0, 16'h0022);
    step();
    update = 1'b0;
    lookup(16'h0010);
    n_tests++;
    if (predict_taken !== 1'b0 || predicted_PC !== 16'h0012) begin
      n_fail++; $display("FAIL alias_old got %0b/%h exp 0/0012", predict_taken, predicted_PC);
    end
    lookup(16'h0020);
    n_tests++;
    if (predict_taken !== 1'b1 || predicted_PC !== 16'h0200) begin
      n_fail++; $display("FAIL alias_new got %0b/%h exp 1/0200", predict_taken, predicted_PC);
    end
    n_tests++;
    if (br_count !== 16'd9 || mis_count !== 16'd4) begin
      n_fail++; $display("FAIL alias_cnt got %0d/%0d exp 9/4", br_count, mis_count);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    set_br(16'h0030, 1'b1, 16'h0300, 1'b0, 16'h0032);
    n_tests++;
    if (mispredicted !== 1'b1) begin
      n_fail++; $display("FAIL stall_mis got %0b exp 1", mispredicted);
    end
    step();
    update = 1'b0;
    stall  = 1'b0;
    lookup(16'h0030);
    n_tests++;
    if (predict_taken !== 1'b0 || predicted_PC !== 16'h0032) begin
      n_fail++; $display("FAIL stall_noalloc got %0b/%h exp 0/0032", predict_taken, predicted_PC);
    end
    lookup(16'h0020);
    n_tests++;
    if (predict_taken !== 1'b1 || predicted_PC !== 16'h0200) begin
      n_fail++; $display("FAIL stall_keep got %0b/%h exp 1/0200", predict_taken, predicted_PC);
    end
    n_tests++;
    if (br_count !== 16'd9 || mis_count !== 16'd4) begin
      n_fail++; $display("FAIL stall_cnt got %0d/%0d exp 9/4", br_count, mis_count);
    end
  endtask

  task automatic test_target_change();
    set_br(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0012);
    step();
    set_br(16'h0010, 1'b1, 16'h0080, 1'b1, 16'h0040);
    n_tests++;
    if (mispredicted !== 1'b1 || recovery_PC !== 16'h0080) begin
      n_fail++; $display("FAIL tgt_mis got %0b/%h exp 1/0080", mispredicted, recovery_PC);
    end
    step();
    update = 1'b0;
    lookup(16'h0010);
    n_tests++;
    if (predict_taken !== 1'b1 || predicted_PC !== 16'h0080) begin
      n_fail++; $display("FAIL tgt_new got %0b/%h exp 1/0080", predict_taken, predicted_PC);
    end
    n_tests++;
    if (br_count !== 16'd11 || mis_count !== 16'd6) begin
      n_fail++; $display("FAIL tgt_cnt got %0d/%0d exp 11/6", br_count, mis_count);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    set_br(16'h0050, 1'b1, 16'h0500, 1'b0, 16'h0052);
    step();
    rst    = 1'b0;
    update = 1'b0;
    lookup(16'h0050);
    n_tests++;
    if (predict_taken !== 1'b0 || predicted_PC !== 16'h0052) begin
      n_fail++; $display("FAIL rstpri_noalloc got %0b/%h exp 0/0052", predict_taken, predicted_PC);
    end
    lookup(16'h0010);
    n_tests++;
    if (predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL rstpri_clear got %0b exp 0", predict_taken);
    end
    n_tests++;
    if (br_count !== 16'd0 || mis_count !== 16'd0) begin
      n_fail++; $display("FAIL rstpri_cnt got %0d/%0d exp 0/0", br_count, mis_count);
    end
  endtask

  initial begin
    rst = 1'b1; update = 1'b0; stall = 1'b0;
    PC_curr = 16'h0; PC_next = 16'h2;
    br_PC = 16'h0; br_PC_next = 16'h2;
    actual_taken = 1'b0; actual_target = 16'h0;
    pred_taken_ID = 1'b0; pred_target_ID = 16'h0;
    test_reset();
    test_allocate();
    test_saturation();
    test_not_taken_miss();
    test_alias();
    test_stall();
    test_target_change();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
